// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage divider.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIVZERO = 2'd1,
    ON      = 2'd2,
    END     = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
// Handshake: start_i is level-held by the requester until ready_o, a one-cycle pulse.
module div_radix2
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               signed_div_i,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t         state_q, state_d;
  logic [2*WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               qsign_q, qsign_d;
  logic               rsign_q, rsign_d;
  logic               ready_q, ready_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               abort;
  logic               sign1, sign2;
  logic [WIDTH-1:0]   abs1, abs2;
  logic [2*WIDTH:0]   shifted;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] sreg_step;
  logic [WIDTH-1:0]   rem_mag, quo_mag;

  always_comb begin
    abort = flush | annul_i;
    sign1 = signed_div_i & opdata1_i[WIDTH-1];
    sign2 = signed_div_i & opdata2_i[WIDTH-1];
    abs1  = sign1 ? (~opdata1_i + 1'b1) : opdata1_i;
    abs2  = sign2 ? (~opdata2_i + 1'b1) : opdata2_i;

    // sreg holds {partial_rem, dividend/quotient}; quotient bits enter at the LSB.
    shifted = {sreg_q, 1'b0};
    trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    if (!trial[WIDTH]) begin
      sreg_step = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
    end else begin
      sreg_step = shifted[2*WIDTH-1:0];
    end

    rem_mag = sreg_q[2*WIDTH-1:WIDTH];
    quo_mag = sreg_q[WIDTH-1:0];

    state_d   = state_q;
    sreg_d    = sreg_q;
    divisor_d = divisor_q;
    cnt_d     = cnt_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    ready_d   = 1'b0;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (start_i && !abort) begin
          divisor_d = abs2;
          cnt_d     = '0;
          if (opdata2_i == '0) begin
            // Divide-by-zero yields a fixed pattern: raw dividend as remainder, all-ones quotient.
            sreg_d  = {opdata1_i, {WIDTH{1'b1}}};
            qsign_d = 1'b0;
            rsign_d = 1'b0;
            state_d = DIVZERO;
          end else begin
            sreg_d  = {{WIDTH{1'b0}}, abs1};
            qsign_d = sign1 ^ sign2;
            rsign_d = sign1;
            state_d = ON;
          end
        end
      end
      ON: begin
        sreg_d = sreg_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = END;
        end
      end
      DIVZERO: begin
        state_d = END;
      end
      END: begin
        ready_d  = 1'b1;
        result_d = {rsign_q ? (~rem_mag + 1'b1) : rem_mag,
                    qsign_q ? (~quo_mag + 1'b1) : quo_mag};
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      divisor_q <= '0;
      cnt_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      ready_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      divisor_q <= divisor_d;
      cnt_q     <= cnt_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = ready_q;
  assign result_o = result_q;

endmodule
